// File: rtl/param_lfsr_xor_cipher.sv
// XOR stream cipher whose keystream comes from NUM_LFSR Galois LFSRs, with
// runtime seed loading, selectable keystream modes and periodic rekey.
//
// state   | meaning
// IDLE    | ready for a word; seed writes are accepted here
// OUT     | result word presented on m_data, waiting for m_ready
// ADVANCE | all LFSRs stepping DATA_W times before the next word
module param_lfsr_xor_cipher #(
  parameter int M            = 32,
  parameter int DATA_W       = 8,
  parameter int NUM_LFSR     = 2,
  parameter logic [NUM_LFSR*M-1:0] POLYS = {NUM_LFSR{32'h80200003}},
  parameter int REKEY_PERIOD = 0,
  localparam int SEL_W       = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              seed_wr,
  input  logic [SEL_W-1:0]  seed_sel,
  input  logic [M-1:0]      seed_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [31:0]       word_cnt
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, OUT, ADVANCE} state_t;

  state_t                     state, state_nxt;
  logic [NUM_LFSR-1:0][M-1:0] st, seed;
  logic [1:0]                 mode_r;
  logic [CW-1:0]              step_cnt;
  logic [31:0]                rekey_cnt;
  logic [DATA_W-1:0]          ks;
  logic [M-1:0]               seed_val;
  logic                       last_step, rekey_now;

  function automatic logic [M-1:0] lfsr_step(input logic [M-1:0] s, input logic [M-1:0] p);
    return (s >> 1) ^ (s[0] ? p : '0);
  endfunction

  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_val  = (seed_data == '0) ? M'(1) : seed_data;
  assign last_step = (state == ADVANCE) && (step_cnt == CW'(1));
  assign rekey_now = (REKEY_PERIOD > 0) && (rekey_cnt == 32'(REKEY_PERIOD));

  always_comb begin
    ks = '0;
    case (mode)
      2'd0:    ks = '0;
      2'd2:    ks = st[0][DATA_W-1:0];
      default: for (int i = 0; i < NUM_LFSR; i++) ks = ks ^ st[i][DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = (mode_r == 2'd0) ? IDLE : ADVANCE;
      ADVANCE: if (step_cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == IDLE);
    m_valid = (state == OUT);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LFSR; i++) begin
        st[i]   <= M'(i + 1);
        seed[i] <= M'(i + 1);
      end
      m_data    <= '0;
      mode_r    <= 2'd0;
      step_cnt  <= '0;
      rekey_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The keystream for a same-cycle accept is taken from the old states.
          for (int i = 0; i < NUM_LFSR; i++) begin
            if (seed_wr && (seed_sel == SEL_W'(i))) begin
              seed[i] <= seed_val;
              st[i]   <= seed_val;
            end
          end
          if (s_valid) begin
            m_data <= s_data ^ ks;
            mode_r <= mode;
          end
        end
        OUT: begin
          if (m_ready) begin
            word_cnt <= word_cnt + 32'd1;
            if (mode_r != 2'd0) begin
              step_cnt <= CW'(DATA_W);
              if (REKEY_PERIOD > 0) rekey_cnt <= rekey_cnt + 32'd1;
            end
          end
        end
        ADVANCE: begin
          step_cnt <= step_cnt - CW'(1);
          if (last_step && rekey_now) begin
            st        <= seed;
            rekey_cnt <= '0;
          end else begin
            for (int i = 0; i < NUM_LFSR; i++) st[i] <= lfsr_step(st[i], POLYS[i*M +: M]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_lfsr_xor_cipher.sv
// Directed bench for param_lfsr_xor_cipher: a default instance plus a
// REKEY_PERIOD=4 instance sharing the same stimulus.
module tb_param_lfsr_xor_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        seed_wr = 1'b0;
  logic [0:0]  seed_sel = 1'b0;
  logic [31:0] seed_data = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid, busy;
  logic [7:0]  m_data;
  logic [31:0] word_cnt;
  logic        s_ready_rk, m_valid_rk, busy_rk;
  logic [7:0]  m_data_rk;
  logic [31:0] word_cnt_rk;

  int errors = 0;
  int checks = 0;
  logic [31:0] mst [2];

  always #5 clk = ~clk;

  param_lfsr_xor_cipher dut (
    .clk(clk), .rst(rst), .mode(mode), .seed_wr(seed_wr), .seed_sel(seed_sel),
    .seed_data(seed_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .word_cnt(word_cnt)
  );

  param_lfsr_xor_cipher #(.REKEY_PERIOD(4)) dut_rk (
    .clk(clk), .rst(rst), .mode(mode), .seed_wr(seed_wr), .seed_sel(seed_sel),
    .seed_data(seed_data), .s_valid(s_valid), .s_ready(s_ready_rk), .s_data(s_data),
    .m_valid(m_valid_rk), .m_ready(m_ready), .m_data(m_data_rk), .busy(busy_rk),
    .word_cnt(word_cnt_rk)
  );

  function automatic logic [31:0] gstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Reference keystream for the next word; advances the reference LFSRs.
  task automatic model_ks(input logic [1:0] md, output logic [7:0] k);
    if (md == 2'd0)      k = 8'h00;
    else if (md == 2'd2) k = mst[0][7:0];
    else                 k = mst[0][7:0] ^ mst[1][7:0];
    if (md != 2'd0)
      for (int s = 0; s < 8; s++) begin
        mst[0] = gstep(mst[0]);
        mst[1] = gstep(mst[1]);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; seed_wr = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mst[0] = 32'd1;
    mst[1] = 32'd2;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!s_ready && n < 40) begin @(negedge clk); n++; end
    if (!s_ready) begin
      errors++; checks++;
      $display("FAIL idle_timeout: s_ready=%0b required 1", s_ready);
    end
  endtask

  task automatic load_seed(input logic sel, input logic [31:0] d);
    wait_idle();
    seed_wr = 1'b1; seed_sel = sel; seed_data = d;
    @(negedge clk);
    seed_wr = 1'b0;
    mst[sel] = (d == 32'd0) ? 32'd1 : d;
  endtask

  task automatic send(input logic [7:0] d, output logic [7:0] q, output logic [7:0] q2, output int lat);
    wait_idle();
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!m_valid) begin
      errors++; checks++;
      $display("FAIL m_valid_timeout: m_valid=%0b required 1", m_valid);
    end
    q = m_data; q2 = m_data_rk;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (s_ready !== 1'b1)    begin errors++; $display("FAIL rst_s_ready: got %0b want 1", s_ready); end
    if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
    if (m_data !== 8'h00)    begin errors++; $display("FAIL rst_m_data: got %h want 00", m_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    if (word_cnt !== 32'd0)  begin errors++; $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); end
  endtask

  task automatic test_first_words();
    logic [7:0] q, q2;
    int lat;
    do_reset();
    mode = 2'd2;
    send(8'h00, q, q2, lat);
    checks += 2;
    if (lat !== 0)    begin errors++; $display("FAIL latency: got %0d want 0", lat); end
    if (q !== 8'h01)  begin errors++; $display("FAIL mode2_first: got %h want 01", q); end
    // After 8 steps: st0 = DB36C002, st1 = B62D8003 -> low bytes 02^03
    mode = 2'd1;
    send(8'h00, q, q2, lat);
    checks++;
    if (q !== 8'h01)  begin errors++; $display("FAIL mode1_second: got %h want 01", q); end
    do_reset();
    mode = 2'd1;
    send(8'h00, q, q2, lat);
    checks += 2;
    if (q !== 8'h03)  begin errors++; $display("FAIL mode1_first: got %h want 03", q); end
    if (word_cnt !== 32'd1) begin errors++; $display("FAIL word_cnt_one: got %0d want 1", word_cnt); end
  endtask

  task automatic test_cancel();
    logic [7:0] d, q, q2;
    int lat;
    do_reset();
    load_seed(1'b0, 32'hDEADBEEF);
    load_seed(1'b1, 32'hDEADBEEF);
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      send(d, q, q2, lat);
      checks++;
      if (q !== d) begin errors++; $display("FAIL cancel[%0d]: got %h want %h", i, q, d); end
    end
    checks++;
    if (word_cnt !== 32'd16) begin errors++; $display("FAIL cancel_word_cnt: got %0d want 16", word_cnt); end
  endtask

  task automatic test_roundtrip();
    logic [7:0] pt [32];
    logic [7:0] ct [32];
    logic [7:0] q, q2, k;
    int lat;
    do_reset();
    load_seed(1'b0, 32'h12345678);
    load_seed(1'b1, 32'h0BADF00D);
    mode = 2'd1;
    for (int i = 0; i < 32; i++) begin
      pt[i] = 8'(i * 29 + 7);
      send(pt[i], q, q2, lat);
      ct[i] = q;
      model_ks(2'd1, k);
      checks++;
      if (q !== (pt[i] ^ k)) begin errors++; $display("FAIL encrypt[%0d]: got %h want %h", i, q, pt[i] ^ k); end
    end
    do_reset();
    load_seed(1'b0, 32'h12345678);
    load_seed(1'b1, 32'h0BADF00D);
    for (int i = 0; i < 32; i++) begin
      send(ct[i], q, q2, lat);
      checks++;
      if (q !== pt[i]) begin errors++; $display("FAIL decrypt[%0d]: got %h want %h", i, q, pt[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q, q2, k, hold;
    int lat;
    do_reset();
    mode = 2'd1;
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge clk);
    s_valid = 1'b0;
    model_ks(2'd1, k);
    hold = m_data;
    checks++;
    if (hold !== (8'h5A ^ k)) begin errors++; $display("FAIL bp_first: got %h want %h", hold, 8'h5A ^ k); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        seed_wr = 1'b1; seed_sel = 1'b0; seed_data = 32'h0F0F0F0F;
        mode = 2'd0;
      end
      @(negedge clk);
      seed_wr = 1'b0;
      checks += 3;
      if (m_data !== hold)  begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", c, m_data, hold); end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d]: got %0b want 0", c, s_ready); end
      if (busy !== 1'b1)    begin errors++; $display("FAIL bp_busy[%0d]: got %0b want 1", c, busy); end
    end
    mode = 2'd1;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    send(8'h00, q, q2, lat);
    model_ks(2'd1, k);
    checks++;
    if (q !== k) begin errors++; $display("FAIL bp_next: got %h want %h", q, k); end
  endtask

  task automatic test_rekey();
    logic [7:0] pat [4];
    logic [7:0] out [8];
    logic [7:0] q, q2;
    int lat;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h00; pat[3] = 8'hFF;
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 8; i++) begin
      send(pat[i % 4], q, q2, lat);
      out[i] = q2;
    end
    checks++;
    if (out[0] !== (8'hA5 ^ 8'h03)) begin errors++; $display("FAIL rekey_first: got %h want %h", out[0], 8'hA5 ^ 8'h03); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out[i+4] !== out[i]) begin errors++; $display("FAIL rekey_repeat[%0d]: got %h want %h", i, out[i+4], out[i]); end
    end
  endtask

  task automatic test_zero_seed_and_reset();
    logic [7:0] q, q2;
    int lat;
    do_reset();
    load_seed(1'b0, 32'h00000055);
    load_seed(1'b0, 32'h00000000);
    mode = 2'd2;
    send(8'h00, q, q2, lat);
    checks++;
    if (q !== 8'h01) begin errors++; $display("FAIL zero_seed: got %h want 01", q); end
    send(8'h00, q, q2, lat);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (m_valid !== 1'b0)   begin errors++; $display("FAIL midrst_m_valid: got %0b want 0", m_valid); end
    if (s_ready !== 1'b1)   begin errors++; $display("FAIL midrst_s_ready: got %0b want 1", s_ready); end
    if (word_cnt !== 32'd0) begin errors++; $display("FAIL midrst_word_cnt: got %0d want 0", word_cnt); end
    @(negedge clk);
    rst = 1'b0;
    mst[0] = 32'd1;
    mst[1] = 32'd2;
    @(negedge clk);
    mode = 2'd2;
    send(8'h00, q, q2, lat);
    checks++;
    if (q !== 8'h01) begin errors++; $display("FAIL after_rst: got %h want 01", q); end
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_cancel();
    test_roundtrip();
    test_backpressure();
    test_rekey();
    test_zero_seed_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_lfsr_xor_cipher.md
Name: param_lfsr_xor_cipher

Overview:
Parametrised successor to the dual-LFSR XOR cipher core. It combines NUM_LFSR Galois LFSRs of width M into one keystream and XORs that keystream with DATA_W-bit words over valid/ready streams. It adds runtime seed loading, selectable keystream modes and a periodic rekey counter. It sits between the UART receive path and the UART transmit scheduler in the FPGA wrapper.

Parameters:
M, 32, LFSR width (>= DATA_W, >= 4)
DATA_W, 8, data word width
NUM_LFSR, 2, number of LFSRs (>= 1)
POLYS, {NUM_LFSR{32'h80200003}}, packed NUM_LFSR*M feedback masks; slice i belongs to LFSR i
REKEY_PERIOD, 0, number of words between automatic reloads of stored seeds; 0 disables rekey

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mode  in  2  keystream mode: 0 = bypass, 1 = XOR of all LFSRs, 2 = LFSR0 only, 3 = same as 1
seed_wr  in  1  seed write strobe
seed_sel  in  max(1,$clog2(NUM_LFSR))  target LFSR index
seed_data  in  M  seed value
s_valid  in  1  input word valid
s_ready  out  1  core can accept an input word
s_data  in  DATA_W  plaintext or ciphertext in
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the output word
m_data  out  DATA_W  XOR result
busy  out  1  high in any state other than IDLE
word_cnt  out  32  count of output words delivered since reset; wraps at 2^32

Behaviour:
- Reset, asynchronous:
  - state = IDLE; s_ready = 1; m_valid = 0; m_data = 0; busy = 0; word_cnt = 0.
  - Stored seed i and LFSR state i both = i+1.
  - Rekey counter = 0.
- LFSR step, Galois right shift: next = (st>>1) ^ (st[0] ? POLY_i : 0).
- Keystream ks:
  - mode 1/3: XOR over i of st_i[DATA_W-1:0].
  - mode 2: st_0[DATA_W-1:0].
  - mode 0: 0.
- IDLE:
  - s_ready = 1.
  - seed_wr: stored seed[seed_sel] and st[seed_sel] are both written. A value of 0 is written as 1 (lock-up guard). seed_sel >= NUM_LFSR is ignored.
  - s_valid (handshake): m_data <= s_data ^ ks. mode is sampled here. Go to OUT. m_valid rises on the next cycle (latency 1).
  - seed_wr and s_valid in the same cycle: the seed write takes effect and the word uses the old states.
- OUT:
  - m_valid = 1; s_ready = 0.
  - m_data is held stable until m_ready.
  - On m_valid & m_ready: m_valid <= 0 and word_cnt++.
    - Sampled mode 0: return to IDLE; no LFSR advance; no rekey count.
    - Otherwise: go to ADVANCE with step counter = DATA_W.
- ADVANCE:
  - s_ready = 0. All LFSRs step once per cycle for DATA_W cycles, then return to IDLE.
  - Throughput is 1 word per DATA_W+2 cycles (non-bypass, m_ready high).
- Rekey (REKEY_PERIOD > 0):
  - The rekey counter increments on each non-bypass output handshake.
  - When it reaches REKEY_PERIOD, the final ADVANCE cycle loads st_i = stored seed i instead of stepping, and the counter is cleared.
- seed_wr outside IDLE is ignored (dropped, not queued).
- mode changes outside IDLE have no effect until the next accept.
- Reset asserted mid-OUT or mid-ADVANCE: immediate return to the reset values. A pending output word is discarded.
- s_data is XOR-symmetric: the same seeds and mode decrypt ciphertext back to plaintext.

Test Plan:
1. Reset, mode 2, send 0x00 -> m_valid one cycle after accept, m_data = 0x01. Then mode 1, send 0x00 -> m_data = 0x00^(st0^st1 low byte), and the first word after reset in mode 1 = 0x03.
2. Equal POLYS, seed both LFSRs 0xDEADBEEF, mode 1, stream 16 random bytes -> every m_data equals s_data (keystream cancels); word_cnt = 16.
3. Seeds 0x12345678 / 0x0BADF00D, mode 1, encrypt 32 bytes; reset, reload the same seeds, feed the ciphertext -> original plaintext recovered bit-exact.
4. Backpressure: hold m_ready = 0 for 5 cycles in OUT -> m_data stable, s_ready = 0, busy = 1; a seed_wr issued during this window is not applied (next output is unchanged versus the golden model).
5. REKEY_PERIOD = 4, mode 1, send the same 4-byte pattern twice -> bytes 5..8 of the output equal bytes 1..4.
6. seed_wr with data 0 -> that LFSR behaves as seeded with 1. Assert rst during ADVANCE -> m_valid = 0, s_ready = 1, word_cnt = 0 immediately, and the next mode 2 word of 0x00 yields 0x01.
